matrix_inv: RTL and testbench

MATRIX_INV -- requirements
Module: matrix_inv

---
 rtl/matrix_pkg.sv | 17 +
 rtl/div324_seq.sv | 43 ++++
 rtl/matrix_inv.sv | 111 +++++++++++
 tb/tb_matrix_inv.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the 2x2 integer transform inverter.
package matrix_pkg;

  localparam int unsigned C21     = 21;
  localparam int unsigned C39     = 39;
  localparam int unsigned C11     = 11;
  localparam int unsigned C5      = 5;
  localparam int unsigned DET_MAG = 324;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div324_seq.sv
// Sequential restoring divider by DET_MAG, one quotient bit per enabled cycle.
// Exposes the next-step quotient/remainder so the caller can register the final step.
module div324_seq
  import matrix_pkg::*;
#(
  parameter int unsigned DW = 39
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  input  logic [DW-1:0] dividend,
  output logic [DW-1:0] quo_c,
  output logic [8:0]    rem_c
);

  logic [DW-1:0] quo_q;
  logic [8:0]    rem_q;
  logic [9:0]    trial;
  logic          ge;

  // Dividend bits shift out of quo_q's MSB while quotient bits shift in at the LSB.
  always_comb begin
    trial = {rem_q, quo_q[DW-1]};
    ge    = (trial >= 10'(DET_MAG));
    rem_c = ge ? 9'(trial - 10'(DET_MAG)) : trial[8:0];
    quo_c = {quo_q[DW-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
    end else if (en) begin
      quo_q <= quo_c;
      rem_q <= rem_c;
    end
  end

endmodule

// File: rtl/matrix_inv.sv
// Inverts y1=21*x1+39*x2, y2=11*x1+5*x2 with shift-add numerators and two
// parallel sequential dividers; flags inputs that are not exact unsigned images.
module matrix_inv
  import matrix_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] y2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x1,
  output logic [W-1:0] x2,
  output logic         err
);

  localparam int unsigned NW = W + 8;
  localparam int unsigned DW = W + 7;
  localparam int unsigned CW = $clog2(W + 8);

  state_t        state;
  logic [W-1:0]  y1_q, y2_q;
  logic [CW-1:0] cnt;
  logic          neg1_q, neg2_q;

  logic [NW-1:0] n1_c, n2_c, mag1_c, mag2_c;
  logic [DW-1:0] quo1_c, quo2_c;
  logic [8:0]    rem1_c, rem2_c;
  logic          err_c;

  // Constant multiply as a sum of shifted copies, one per set coefficient bit.
  function automatic logic [NW-1:0] sa(input logic [NW-1:0] v, input int unsigned c);
    logic [NW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++)
      if (c[i]) acc = acc + (v << i);
    return acc;
  endfunction

  always_comb begin
    n1_c   = sa(NW'(y2_q), C39) - sa(NW'(y1_q), C5);
    n2_c   = sa(NW'(y1_q), C11) - sa(NW'(y2_q), C21);
    mag1_c = n1_c[NW-1] ? (~n1_c + NW'(1)) : n1_c;
    mag2_c = n2_c[NW-1] ? (~n2_c + NW'(1)) : n2_c;
    err_c  = neg1_q || neg2_q || (rem1_c != '0) || (rem2_c != '0) ||
             (quo1_c[DW-1:W] != '0) || (quo2_c[DW-1:W] != '0);
  end

  div324_seq #(.DW(DW)) u_div1 (
    .clk(clk), .rst(rst), .start(state == CALC), .en(state == DIV),
    .dividend(DW'(mag1_c)), .quo_c(quo1_c), .rem_c(rem1_c)
  );

  div324_seq #(.DW(DW)) u_div2 (
    .clk(clk), .rst(rst), .start(state == CALC), .en(state == DIV),
    .dividend(DW'(mag2_c)), .quo_c(quo2_c), .rem_c(rem2_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x1        <= '0;
      x2        <= '0;
      err       <= 1'b0;
      y1_q      <= '0;
      y2_q      <= '0;
      cnt       <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          y1_q     <= y1;
          y2_q     <= y2;
          in_ready <= 1'b0;
          state    <= CALC;
        end
        CALC: begin
          neg1_q <= n1_c[NW-1];
          neg2_q <= n2_c[NW-1];
          cnt    <= '0;
          state  <= DIV;
        end
        // The last divider step is taken from the next-step outputs on the same edge.
        DIV: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            err       <= err_c;
            x1        <= err_c ? '0 : quo1_c[W-1:0];
            x2        <= err_c ? '0 : quo2_c[W-1:0];
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_inv.sv
// Randomized self-checking bench for matrix_inv against an integer-arithmetic model.
module tb_matrix_inv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] y1, y2, x1, x2;

  int n_checks = 0;
  int n_errors = 0;

  matrix_inv #(.W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y1(y1), .y2(y2), .out_valid(out_valid), .out_ready(out_ready),
    .x1(x1), .x2(x2), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Solve the 2x2 system directly with wide signed integers.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output longint ex1, output longint ex2, output bit ee);
    longint n1, n2;
    n1  = 39 * longint'(b) - 5 * longint'(a);
    n2  = 11 * longint'(a) - 21 * longint'(b);
    ee  = (n1 < 0) || (n2 < 0) || (n1 % 324 != 0) || (n2 % 324 != 0) ||
          (n1 / 324 >= 64'sh1_0000_0000) || (n2 / 324 >= 64'sh1_0000_0000);
    ex1 = ee ? 0 : n1 / 324;
    ex2 = ee ? 0 : n2 / 324;
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int hold);
    longint ex1, ex2;
    bit     ee;
    int     lat;
    logic [31:0] sx1, sx2;
    logic        serr;
    model(a, b, ex1, ex2, ee);
    @(negedge clk);
    y1 = a; y2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    y1 = $urandom; y2 = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd40);
    check("x1", 64'(x1), 64'(ex1));
    check("x2", 64'(x2), 64'(ex2));
    check("err", 64'(err), 64'(ee));
    sx1 = x1; sx2 = x2; serr = err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; y1 = $urandom; y2 = $urandom;
      check("bp_x1", 64'(x1), 64'(sx1));
      check("bp_x2", 64'(x2), 64'(sx2));
      check("bp_err", 64'(err), 64'(serr));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_out_valid", 64'(out_valid), 64'd0);
    check("ret_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] a, b, r1, r2;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; y1 = '0; y2 = '0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_x1", 64'(x1), 64'd0);
    check("rst_x2", 64'(x2), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run_txn(32'd60, 32'd16, 0);
    run_txn(32'd2217, 32'd1115, 0);
    run_txn(32'h03C0_0000, 32'h0100_0000, 0);
    run_txn(32'd0, 32'd0, 0);
    run_txn(32'd1, 32'd0, 0);
    run_txn(32'd0, 32'd1, 0);
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_txn(32'd2217, 32'd1115, 5);

    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) begin
        a = $urandom; b = $urandom;
      end else begin
        r1 = $urandom_range(0, 32'h03FF_FFFF);
        r2 = $urandom_range(0, 32'h03FF_FFFF);
        a = 21 * r1 + 39 * r2;
        b = 11 * r1 + 5 * r2;
      end
      run_txn(a, b, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of the divide; x1/x2 still hold the previous (1,1) result.
    run_txn(32'd60, 32'd16, 0);
    @(negedge clk);
    y1 = 32'd2217; y2 = 32'd1115; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_x1", 64'(x1), 64'd0);
    check("mid_rst_x2", 64'(x2), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", 64'(seen), 64'd0);
    run_txn(32'd60, 32'd16, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
